// File: rtl/dlx_icache_pkg.sv
// rtl/dlx_icache_pkg.sv - shared DLX types and instruction-cache defaults
package dlx_icache_pkg;

    typedef logic [31:0] dlx_word;
    typedef logic [31:0] dlx_address;

    localparam int IC_LINES          = 16;
    localparam int IC_WORDS_PER_LINE = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } ic_state_t;

endpackage

// File: rtl/dlx_icache_fill.sv
// rtl/dlx_icache_fill.sv - line refill sequencer driving the memory req/ack bus
module dlx_icache_fill
    import dlx_icache_pkg::*;
#(
    parameter int LINES          = IC_LINES,
    parameter int WORDS_PER_LINE = IC_WORDS_PER_LINE,
    localparam int OFF_W  = $clog2(WORDS_PER_LINE),
    localparam int IDX_W  = $clog2(LINES),
    localparam int TAG_W  = 30 - OFF_W - IDX_W,
    localparam int LINE_W = IDX_W + TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_i,
    input  logic [LINE_W-1:0] miss_line_i,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    output logic              idle_o,
    output logic              fill_we_o,
    output logic [IDX_W-1:0]  fill_idx_o,
    output logic [OFF_W-1:0]  fill_off_o,
    output logic [TAG_W-1:0]  fill_tag_o,
    output logic [31:0]       fill_wdata_o,
    output logic              fill_done_o
);

    ic_state_t         state_q, state_d;
    logic [OFF_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              mem_req_q, mem_req_d;
    logic              last_word;

    // Words per line is a power of two, so the last word is the all-ones count.
    assign last_word = &word_cnt_q;

    // Next-state: latch the missing line in IDLE, walk its words in FILL.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_d     = line_q;
        mem_req_d  = mem_req_q;
        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    line_d     = miss_line_i;
                    word_cnt_d = '0;
                    mem_req_d  = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_ack_i) begin
                    if (last_word) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any refill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            line_q     <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_q     <= line_d;
            mem_req_q  <= mem_req_d;
        end
    end

    // Address only moves on an accepted ack, so it is stable across wait cycles.
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = {line_q, word_cnt_q, 2'b00};
    assign idle_o       = (state_q == IDLE);
    // Acks outside FILL arrive with mem_req low and are ignored here.
    assign fill_we_o    = (state_q == FILL) && mem_ack_i;
    assign fill_done_o  = fill_we_o && last_word;
    assign fill_idx_o   = line_q[IDX_W-1:0];
    assign fill_tag_o   = line_q[IDX_W +: TAG_W];
    assign fill_off_o   = word_cnt_q;
    assign fill_wdata_o = mem_rdata_i;

endmodule

// File: rtl/dlx_icache.sv
// rtl/dlx_icache.sv - direct-mapped read-only instruction cache for the DLX fetch stage
module dlx_icache
    import dlx_icache_pkg::*;
#(
    parameter int LINES          = IC_LINES,
    parameter int WORDS_PER_LINE = IC_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ic_addr_i,
    output logic [31:0] ic_data_o,
    output logic        ic_wait_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int OFF_W    = $clog2(WORDS_PER_LINE);
    localparam int IDX_W    = $clog2(LINES);
    localparam int TAG_W    = 30 - OFF_W - IDX_W;
    localparam int LINE_LSB = 2 + OFF_W;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_byte_bits;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    logic             hit;
    logic             idle;
    logic             fill_we;
    logic             fill_done;
    logic [IDX_W-1:0] fill_idx;
    logic [OFF_W-1:0] fill_off;
    logic [TAG_W-1:0] fill_tag;
    logic [31:0]      fill_wdata;

    assign off              = ic_addr_i[2 +: OFF_W];
    assign idx              = ic_addr_i[LINE_LSB +: IDX_W];
    assign tag              = ic_addr_i[LINE_LSB + IDX_W +: TAG_W];
    assign unused_byte_bits = ^ic_addr_i[1:0];

    // Lookups only count in IDLE, so a half-written line is never returned.
    assign hit       = valid_q[idx] && (tag_q[idx] == tag) && idle;
    assign ic_wait_o = !hit;
    assign ic_data_o = hit ? data_q[idx][off] : '0;

    dlx_icache_fill #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_fill (
        .clk          (clk),
        .rst          (rst),
        .miss_i       (!hit),
        .miss_line_i  (ic_addr_i[31:LINE_LSB]),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .idle_o       (idle),
        .fill_we_o    (fill_we),
        .fill_idx_o   (fill_idx),
        .fill_off_o   (fill_off),
        .fill_tag_o   (fill_tag),
        .fill_wdata_o (fill_wdata),
        .fill_done_o  (fill_done)
    );

    // Flush clears everything, but a line completing this cycle still lands valid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end
        if (fill_done) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // Valid bits are the only cache state that must come out of reset known.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays: written by the refill sequencer, contents don't-care at reset.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
        if (fill_we) begin
            data_q[fill_idx][fill_off] <= fill_wdata;
        end
    end

endmodule

// File: tb/tb_dlx_icache.sv
// tb/tb_dlx_icache.sv - self-checking bench for dlx_icache
module tb_dlx_icache;

    logic        clk;
    logic        rst;
    logic [31:0] ic_addr;
    logic [31:0] ic_data;
    logic        ic_wait;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int cnt = 0;
    int ack_count = 0;
    bit spur = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        bit          miss;
    } vec_t;

    vec_t vecs[10];

    dlx_icache dut (
        .clk         (clk),
        .rst         (rst),
        .ic_addr_i   (ic_addr),
        .ic_data_o   (ic_data),
        .ic_wait_o   (ic_wait),
        .flush_i     (flush),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_00A0 + (a >> 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < 4; i++) sb_q.push_back((a & 32'hFFFF_FFF0) + 32'(4 * i));
    endtask

    task automatic count_wait(output int w);
        #1;
        w = 0;
        while (ic_wait === 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d, input int exp_w,
                         input bit miss, input string nm);
        int w;
        @(negedge clk);
        if (miss) push_line(a);
        ic_addr = a;
        count_wait(w);
        chk({nm, " wait"}, 32'(w), 32'(exp_w));
        chk({nm, " data"}, ic_data, exp_d);
    endtask

    // Memory model: answers each request after lat idle cycles and checks the address
    // against the scoreboard front on every cycle the request is up.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (mem_req) begin
            if (sb_q.size() == 0) begin
                chk("mem_req unexpected", {31'b0, mem_req}, 32'h0);
            end else begin
                chk("mem_addr", mem_addr, sb_q[0]);
            end
            if (cnt >= lat) begin
                mem_ack = 1'b1;
                mem_rdata = mem_word(mem_addr);
                cnt = 0;
                ack_count++;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end else begin
                mem_ack = 1'b0;
                cnt++;
            end
        end else begin
            mem_ack = spur;
            mem_rdata = 32'hDEAD_BEEF;
            cnt = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int t;
        int base;
        vecs[0] = '{32'h0000_0000, 32'h0000_00A0, 5, 1'b1};
        vecs[1] = '{32'h0000_0008, 32'h0000_00A2, 0, 1'b0};
        vecs[2] = '{32'h0000_000C, 32'h0000_00A3, 0, 1'b0};
        vecs[3] = '{32'h0000_0004, 32'h0000_00A1, 0, 1'b0};
        vecs[4] = '{32'h0000_0010, 32'h0000_00A4, 5, 1'b1};
        vecs[5] = '{32'h0000_0014, 32'h0000_00A5, 0, 1'b0};
        vecs[6] = '{32'h0000_0100, 32'h0000_00E0, 5, 1'b1};
        vecs[7] = '{32'h0000_010C, 32'h0000_00E3, 0, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h0000_00A0, 5, 1'b1};
        vecs[9] = '{32'h0000_0018, 32'h0000_00A6, 0, 1'b0};

        rst = 1'b1;
        ic_addr = 32'h0;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        #12;
        chk("reset ic_wait", {31'b0, ic_wait}, 32'h1);
        chk("reset ic_data", ic_data, 32'h0);
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Cold miss, hits, conflict eviction and re-miss.
        foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].data, vecs[i].waits, vecs[i].miss,
                                $sformatf("vec%0d", i));

        // Fetch address moves to a valid line while 0x40 is refilling.
        @(negedge clk);
        push_line(32'h40);
        ic_addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        ic_addr = 32'h0;
        count_wait(w);
        chk("midfill wait", 32'(w + 2), 32'd5);
        chk("midfill data", ic_data, 32'hA0);
        fetch(32'h44, 32'hB1, 0, 1'b0, "midfill line40");

        // Slow memory and spurious acks while idle.
        lat = 3;
        fetch(32'h80, 32'hC0, 17, 1'b1, "slow");
        @(negedge clk);
        spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("spur ic_wait", {31'b0, ic_wait}, 32'h0);
            chk("spur mem_req", {31'b0, mem_req}, 32'h0);
            chk("spur data", ic_data, 32'hC0);
        end
        @(negedge clk);
        spur = 1'b0;
        lat = 0;
        fetch(32'h84, 32'hC1, 0, 1'b0, "after spur");

        // Flush in IDLE: lines 0 and 1 both miss afterwards, no fill starts on the flush itself.
        fetch(32'h10, 32'hA4, 0, 1'b0, "preflush l1");
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush no req", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        push_line(32'h10);
        #1;
        chk("flush no req2", {31'b0, mem_req}, 32'h0);
        count_wait(w);
        chk("flush l1 wait", 32'(w), 32'd5);
        chk("flush l1 data", ic_data, 32'hA4);
        fetch(32'h0, 32'hA0, 5, 1'b1, "flush l0");

        // Flush coinciding with the final ack keeps the new line.
        @(negedge clk);
        push_line(32'h20);
        ic_addr = 32'h20;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flushack wait", {31'b0, ic_wait}, 32'h0);
        chk("flushack data", ic_data, 32'hA8);
        fetch(32'h10, 32'hA4, 5, 1'b1, "flushack other");

        // Reset after two acks of a refill.
        @(negedge clk);
        base = ack_count;
        push_line(32'h40);
        ic_addr = 32'h40;
        t = 0;
        while (ack_count < base + 2 && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("rst acks seen", 32'(ack_count - base), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("rst mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst ic_wait", {31'b0, ic_wait}, 32'h1);
        chk("rst ic_data", ic_data, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        fetch(32'h40, 32'hB0, 5, 1'b1, "post rst 40");
        fetch(32'h20, 32'hA8, 5, 1'b1, "post rst 20");
        chk("sb drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlx_icache.md
# dlx_icache

Direct-mapped, read-only instruction cache serving the DLX instruction-fetch stage. It returns the instruction word for `ic_addr` in the same cycle on a hit. On a miss it raises `ic_wait` and refills the whole line from main memory over a single-word req/ack bus. It sits between the IF pipe stage (`ic_addr`/`ic_data`/`ic_wait`) and the memory arbiter.

## Interface
- `LINES`, default 16: number of cache lines; power of 2, ≥ 2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line; power of 2, ≥ 2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ic_addr`  in  32  fetch byte address (`dlx_address`); bits [1:0] ignored.
- `ic_data`  out  32  instruction word (`dlx_word`); valid only when `ic_wait` = 0.
- `ic_wait`  out  1  miss/refill in progress; IF must hold its PC.
- `flush`  in  1  invalidate all lines; single-cycle pulse.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  32  word-aligned memory byte address.
- `mem_rdata`  in  32  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory data-valid strobe.

## Operation
- Address split: `off` = [2 +: log2(WORDS_PER_LINE)]; `idx` = next log2(LINES) bits; `tag` = remaining upper bits.
- Storage:
  - `valid[LINES]` and `tag_ram[LINES]` are flops.
  - `data_ram[LINES][WORDS_PER_LINE]` is flops with combinational read.
- Hit is `valid[idx] && tag_ram[idx] == tag && state == IDLE`.
  - `ic_wait` = !hit, combinational.
  - `ic_data` = `data_ram[idx][off]` on a hit, otherwise `'0`.
- FSM states:
  - **IDLE**: on a miss, latch the line base address (`ic_addr` with offset and byte bits cleared) into `fill_base`. Clear `word_cnt`, set `mem_req` = 1 with `mem_addr` = `fill_base`, and go to FILL.
  - **FILL**: `mem_addr` = `fill_base` + 4·`word_cnt`. On `mem_ack`:
    - write `mem_rdata` to `data_ram[fill_idx][word_cnt]`.
    - If `word_cnt` = WORDS_PER_LINE−1: set `valid[fill_idx]` = 1, `tag_ram[fill_idx]` = `fill_tag`, `mem_req` = 0, and go to IDLE.
    - Otherwise increment `word_cnt` and keep `mem_req` high.
- Memory handshake:
  - `mem_req` and `mem_addr` stay stable until `mem_ack` is sampled high.
  - `mem_ack` while `mem_req` = 0 is ignored.
  - Back-to-back acks are legal, one word per cycle.
- `ic_addr` changing during FILL: the refill completes for the latched line. Hit/miss is re-evaluated in IDLE against the current `ic_addr`.
- `flush`:
  - Clears all `valid` bits on the next edge.
  - A concurrent FILL continues. Its final-word set of `valid[fill_idx]` wins over a flush in the same cycle.
  - A flush in IDLE with no miss does not start a fill.
- Reset: all `valid` = 0, state = IDLE, `mem_req` = 0, `mem_addr` = 0, `word_cnt` = 0. Tag and data RAM contents are don't-care.
- Outputs during and just after reset:
  - `ic_wait` = 1 (no valid lines).
  - `ic_data` = 0.
- Reset mid-FILL aborts immediately and returns to IDLE with everything invalid.

## Timing
- Hit: 0 wait cycles. `ic_data` is valid in the same cycle as `ic_addr`.
- Miss:
  - Cycle 0: miss detected, `ic_wait` = 1.
  - Cycle 1: `mem_req` = 1.
  - With ack latency A cycles per word, the fill ends after WORDS_PER_LINE·(A+1) cycles.
  - The first cycle back in IDLE gives a hit (`ic_wait` = 0) if `ic_addr` is unchanged.
- Minimum miss penalty with A = 0: 1 + WORDS_PER_LINE cycles of `ic_wait`.
- `ic_wait` is high in every FILL cycle, including the final-ack cycle.

## Structure
- Shared package additions in `dlx_globals.svh`:
  - `IC_LINES` and `IC_WORDS_PER_LINE` defaults.
  - An `ic_state_t` enum {IDLE, FILL}.
  - `dlx_word` and `dlx_address` are reused as-is.
- One sub-module, `dlx_icache_fill`, holds the FSM, `word_cnt`, and the `mem_*` driving. It exposes `fill_we`, `fill_idx`, `fill_off`, `fill_wdata` and `fill_done` to the top-level arrays.

## Test plan
- **Cold miss**: reset, `ic_addr` = 0x0000_0000, mem returns 0xA0..0xA3 with A = 0. Required:
  - `mem_addr` sequence 0x0, 0x4, 0x8, 0xC.
  - `ic_wait` high for 5 cycles.
  - Then `ic_data` = 0xA0; `ic_addr` = 0x8 reads 0xA2 with no wait.
- **Conflict eviction**: fill 0x0000_0000, then fetch 0x0000_0100 (same idx, new tag). Required:
  - Refill from 0x100.
  - A later 0x0 misses again.
- **Slow memory**: A = 3 ack latency. Required:
  - `mem_req`/`mem_addr` are stable across wait cycles.
  - `ic_wait` lasts 1 + 4·4 cycles.
  - Spurious `mem_ack` with `mem_req` = 0 changes nothing.
- **Flush**: fill lines 0 and 1, pulse `flush`. Required:
  - Both lines miss afterwards.
  - A flush in the same cycle as the final ack of a fill leaves that line valid.
- **Address change mid-fill**: miss on 0x40, switch `ic_addr` to 0x0 (valid) during FILL. Required:
  - Line 0x40 completes.
  - `ic_wait` drops in the first IDLE cycle with data from 0x0.
- **Reset mid-fill**: assert `rst` after 2 acks. Required:
  - `mem_req` = 0 immediately.
  - All lines invalid; the next fetch of 0x40 refetches from word 0.
